// File: rtl/alu_74382_pkg.sv
// Shared definitions for the 74382 slice and its nibble-serial controller:
// operand/select widths, opcodes and the controller state type.
package alu_74382_pkg;

   localparam int SELECT_W       = 3;
   localparam int ORIG_OPERAND_W = 4;

   localparam logic [SELECT_W-1:0] OP_CLEAR   = 3'd0;
   localparam logic [SELECT_W-1:0] OP_B_SUB_A = 3'd1;
   localparam logic [SELECT_W-1:0] OP_A_SUB_B = 3'd2;
   localparam logic [SELECT_W-1:0] OP_ADD     = 3'd3;
   localparam logic [SELECT_W-1:0] OP_XOR     = 3'd4;
   localparam logic [SELECT_W-1:0] OP_OR      = 3'd5;
   localparam logic [SELECT_W-1:0] OP_AND     = 3'd6;
   localparam logic [SELECT_W-1:0] OP_PRESET  = 3'd7;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } t_serial_state;

endpackage

// File: rtl/alu_74382_serial_ctrl_if.sv
// Request/response bundle of the serial 74382 controller.
// With ALU_SERIAL_ZERO_FLAG_EN defined the bundle also carries rsp_zero.
interface alu_74382_serial_ctrl_if
   import alu_74382_pkg::*;
#(
   parameter int W = 16
);
   logic                req_valid;
   logic                req_ready;
   logic [SELECT_W-1:0] req_sel;
   logic [W-1:0]        req_a;
   logic [W-1:0]        req_b;
   logic                req_cin;
   logic                rsp_valid;
   logic                rsp_ready;
   logic [W-1:0]        rsp_result;
   logic                rsp_cout;
   logic                rsp_ovr;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   logic                rsp_zero;
`endif

   modport master (
      output req_valid, req_sel, req_a, req_b, req_cin, rsp_ready,
      input  req_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovr
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      , input rsp_zero
`endif
   );

   modport slave (
      input  req_valid, req_sel, req_a, req_b, req_cin, rsp_ready,
      output req_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovr
`ifdef ALU_SERIAL_ZERO_FLAG_EN
      , output rsp_zero
`endif
   );

endinterface

// File: rtl/alu_74382.sv
// Behavioural 4-bit 74382 slice. Arithmetic ops ripple Cn through the slice;
// CLEAR forces Cn+4=OVR=1, other logic ops pass Cn straight to Cn+4 with OVR=0.
module alu_74382
   import alu_74382_pkg::*;
(
   input  logic [SELECT_W-1:0]       s,
   input  logic [ORIG_OPERAND_W-1:0] a,
   input  logic [ORIG_OPERAND_W-1:0] b,
   input  logic                      cn,
   output logic [ORIG_OPERAND_W-1:0] f,
   output logic                      cn4,
   output logic                      ovr
);

   logic [ORIG_OPERAND_W-1:0] x;
   logic [ORIG_OPERAND_W-1:0] y;
   logic [ORIG_OPERAND_W:0]   full_sum;
   logic [ORIG_OPERAND_W-1:0] low_sum;

   always_comb begin
      x = a;
      y = b;
      if (s == OP_B_SUB_A) x = ~a;
      if (s == OP_A_SUB_B) y = ~b;
   end

   // Carry into the sign bit comes from the low three bits; OVR is its XOR with Cn+4.
   assign full_sum = {1'b0, x} + {1'b0, y} + {{ORIG_OPERAND_W{1'b0}}, cn};
   assign low_sum  = {1'b0, x[ORIG_OPERAND_W-2:0]} + {1'b0, y[ORIG_OPERAND_W-2:0]}
                     + {{(ORIG_OPERAND_W-1){1'b0}}, cn};

   always_comb begin
      f   = full_sum[ORIG_OPERAND_W-1:0];
      cn4 = full_sum[ORIG_OPERAND_W];
      ovr = low_sum[ORIG_OPERAND_W-1] ^ full_sum[ORIG_OPERAND_W];
      case (s)
         OP_CLEAR:  begin f = '0;    cn4 = 1'b1; ovr = 1'b1; end
         OP_XOR:    begin f = a ^ b; cn4 = cn;   ovr = 1'b0; end
         OP_OR:     begin f = a | b; cn4 = cn;   ovr = 1'b0; end
         OP_AND:    begin f = a & b; cn4 = cn;   ovr = 1'b0; end
         OP_PRESET: begin f = '1;    cn4 = cn;   ovr = 1'b0; end
         default:   ;
      endcase
   end

endmodule

// File: rtl/alu_74382_serial_ctrl.sv
// Nibble-serial W-bit ALU: one 74382 slice reused over NIBBLES cycles with a
// registered carry chain. Optional rsp_zero output under ALU_SERIAL_ZERO_FLAG_EN.
module alu_74382_serial_ctrl
   import alu_74382_pkg::*;
#(
   parameter  int NIBBLES = 4,
   localparam int W       = NIBBLES * ORIG_OPERAND_W
)(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic [SELECT_W-1:0] req_sel,
   input  logic [W-1:0]        req_a,
   input  logic [W-1:0]        req_b,
   input  logic                req_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [W-1:0]        rsp_result,
   output logic                rsp_cout,
   output logic                rsp_ovr
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   , output logic              rsp_zero
`endif
);

   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

   t_serial_state       state_q, state_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SELECT_W-1:0] sel_q, sel_d;
   logic [W-1:0]        a_q, a_d;
   logic [W-1:0]        b_q, b_d;
   logic                cin_q, cin_d;
   logic                carry_q, carry_d;
   logic [W-1:0]        result_q, result_d;
   logic                cout_q, cout_d;
   logic                ovr_q, ovr_d;

   logic [ORIG_OPERAND_W-1:0] a_nib [NIBBLES];
   logic [ORIG_OPERAND_W-1:0] b_nib [NIBBLES];
   logic [ORIG_OPERAND_W-1:0] slice_a, slice_b, slice_f;
   logic                      slice_cn, slice_cout, slice_ovr;

   genvar gi;
   generate
      for (gi = 0; gi < NIBBLES; gi++) begin : g_nib
         assign a_nib[gi] = a_q[gi*ORIG_OPERAND_W +: ORIG_OPERAND_W];
         assign b_nib[gi] = b_q[gi*ORIG_OPERAND_W +: ORIG_OPERAND_W];
      end
   endgenerate

   assign slice_a  = a_nib[cnt_q];
   assign slice_b  = b_nib[cnt_q];
   assign slice_cn = (cnt_q == '0) ? cin_q : carry_q;

   alu_74382 u_slice (
      .s   (sel_q),
      .a   (slice_a),
      .b   (slice_b),
      .cn  (slice_cn),
      .f   (slice_f),
      .cn4 (slice_cout),
      .ovr (slice_ovr)
   );

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
      a_d      = a_q;
      b_d      = b_q;
      cin_d    = cin_q;
      carry_d  = carry_q;
      result_d = result_q;
      cout_d   = cout_q;
      ovr_d    = ovr_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               sel_d   = req_sel;
               a_d     = req_a;
               b_d     = req_b;
               cin_d   = req_cin;
               cnt_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            for (int i = 0; i < NIBBLES; i++) begin
               if (cnt_q == CNT_W'(i)) result_d[i*ORIG_OPERAND_W +: ORIG_OPERAND_W] = slice_f;
            end
            carry_d = slice_cout;
            if (cnt_q == LAST_NIB) begin
               cout_d  = slice_cout;
               ovr_d   = slice_ovr;
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         sel_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         cin_q    <= 1'b0;
         carry_q  <= 1'b0;
         result_q <= '0;
         cout_q   <= 1'b0;
         ovr_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         sel_q    <= sel_d;
         a_q      <= a_d;
         b_q      <= b_d;
         cin_q    <= cin_d;
         carry_q  <= carry_d;
         result_q <= result_d;
         cout_q   <= cout_d;
         ovr_q    <= ovr_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign rsp_valid  = (state_q == DONE);
   assign rsp_result = result_q;
   assign rsp_cout   = cout_q;
   assign rsp_ovr    = ovr_q;
`ifdef ALU_SERIAL_ZERO_FLAG_EN
   assign rsp_zero   = (state_q == DONE) && (result_q == '0);
`endif

endmodule
